controller_events: RTL
======================

CONTROLLER_EVENTS -- requirements
Module: controller_events

Interface
REQ-001 The block SHALL have parameter NUM_CONT, default 4, meaning number of controllers scanned (1..4).
REQ-002 The block SHALL have parameter KEY_BITS, default 16, meaning key bitmap width per controller (bits [15:0] of the controller key word).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, >=2).
REQ-004 The block SHALL have parameter REPEAT_DELAY, default 500, meaning ticks from a press to the first repeat event.
REQ-005 The block SHALL have parameter REPEAT_RATE, default 100, meaning ticks between subsequent repeat events.
REQ-006 The block SHALL have a single clock domain and an asynchronous, active-low reset.
REQ-007 The block SHALL have port clk, input, 1 bit: the sole clock; all logic is rising-edge.
REQ-008 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port tick, input, 1 bit: a one-cycle timebase strobe for the repeat timers.
REQ-010 The block SHALL have port key_in, input, NUM_CONT x KEY_BITS: per-controller key bitmaps, synchronous to clk.
REQ-011 The block SHALL have port evt_valid, output, 1 bit: event available at the FIFO head.
REQ-012 The block SHALL have port evt_ready, input, 1 bit: consumer accepts the head event.
REQ-013 The block SHALL have port evt_cont, output, 2 bits: controller index of the event, 0-based.
REQ-014 The block SHALL have port evt_key, output, 4 bits: key bit index of the event.
REQ-015 The block SHALL have port evt_kind, output, 2 bits: event kind, PRESS=0, RELEASE=1, REPEAT=2.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag, set when an edge is lost.
REQ-017 The block SHALL have port clear_overflow, input, 1 bit: clears overflow synchronously.

Function
REQ-018 The block SHALL register key_in into a prev array every cycle; an edge on bit k is key_in[k] != prev[k].
REQ-019 A rising edge SHALL set pend_press[c][k], and a falling edge SHALL set pend_rel[c][k]; both are visible the next cycle.
REQ-020 An edge on a bit whose same-kind pending bit is already set SHALL be dropped and SHALL set overflow.
REQ-021 If an edge and a clear_overflow occur in the same cycle, overflow SHALL be 1 afterwards.
REQ-022 A scanner pointer SHALL visit controllers round-robin, advancing by 1 every cycle and wrapping from NUM_CONT-1 to 0.
REQ-023 When the scanner visits controller c and the FIFO is not full, the block SHALL enqueue one event for the lowest-indexed key with any pending bit, clear that pending bit, and enqueue nothing else for c that cycle.
REQ-024 Within one key, pending press/release SHALL take priority over pending repeat.
REQ-025 If both press and release are pending on one key, the block SHALL emit first the edge opposite to the current key_in level (the older edge), then the other on a later visit.
REQ-026 When the FIFO is full, the scanner SHALL continue advancing, enqueue nothing, and keep all pending bits; no event is lost from this cause.
REQ-027 Each controller SHALL have one repeat timer and a rep_key register.
REQ-028 A press edge on key k of controller c SHALL arm the repeat timer: rep_key=k and count=REPEAT_DELAY.
REQ-029 On each tick while armed and key_in[c][rep_key]=1, the counter SHALL decrement; on reaching 0 it SHALL set pend_rep[c][rep_key] and reload REPEAT_RATE.
REQ-030 A repeat expiry while pend_rep is already set SHALL be silently skipped, with no overflow.
REQ-031 A release of rep_key SHALL disarm the timer and clear its pend_rep bit.
REQ-032 A press of a different key SHALL re-arm the timer on the new key.
REQ-033 Latency SHALL be 2 cycles from a key_in change to evt_valid when the FIFO is empty and the scanner reaches that controller in the first cycle, and at most NUM_CONT+1 cycles otherwise.
REQ-034 The FIFO head SHALL pop on evt_valid && evt_ready.
REQ-035 The FIFO outputs SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-036 A simultaneous push and pop on a full FIFO SHALL be allowed (pop first).
REQ-037 A simultaneous push and pop on an empty FIFO SHALL push only, with evt_valid rising the next cycle.

Reset
REQ-038 On reset_n=0, the block SHALL immediately clear prev, all pending masks, timers (disarmed), the scanner (to 0), the FIFO (empty), evt_valid, evt_cont, evt_key, evt_kind and overflow.
REQ-039 Keys held through reset release SHALL generate PRESS events after reset.
REQ-040 An assertion of reset_n=0 mid-operation SHALL discard all queued and pending events.

Structure
REQ-041 Package controller_events_pkg SHALL hold the evt_kind_e enum and the event struct {cont, key, kind}.
REQ-042 The FIFO SHALL be a sub-module, sync_fifo, parametrised by width and depth.

Verification
REQ-043 With NUM_CONT=4, a key_in[2] change 0x0000 -> 0x0011 SHALL produce PRESS(2,0) then PRESS(2,4), with the first evt_valid within 5 cycles.
REQ-044 With evt_ready=0 and 12 distinct presses, 8 events SHALL be queued; after draining, the remaining 4 SHALL arrive in scan order with overflow=0.
REQ-045 Toggling key 3 of controller 0 as press, release, press while stalled SHALL set overflow=1; clear_overflow SHALL then return it to 0.
REQ-046 With REPEAT_DELAY=3, REPEAT_RATE=2 and key 5 held for 9 ticks, the sequence SHALL be PRESS, then REPEAT at ticks 3, 5, 7 and 9, then RELEASE on release.
REQ-047 Asserting reset_n=0 for 1 cycle with 3 events queued SHALL bring evt_valid to 0 immediately; with keys 0x0001 held, a single PRESS(c,0) per controller SHALL follow.

Source files
------------

// File: rtl/controller_events_pkg.sv
// Shared types for the controller key-event scanner.
package controller_events_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_kind_e;

  typedef struct packed {
    logic [1:0] cont;
    logic [3:0] key;
    evt_kind_e  kind;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two. A push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/controller_events.sv
// Scans controller key bitmaps, turns edges and auto-repeat expiries into
// events and queues them in a FIFO for a ready/valid consumer.
module controller_events
  import controller_events_pkg::*;
#(
  parameter int NUM_CONT     = 4,
  parameter int KEY_BITS     = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              tick,
  input  logic [NUM_CONT-1:0][KEY_BITS-1:0] key_in,
  output logic                              evt_valid,
  input  logic                              evt_ready,
  output logic [1:0]                        evt_cont,
  output logic [3:0]                        evt_key,
  output logic [1:0]                        evt_kind,
  output logic                              overflow,
  input  logic                              clear_overflow
);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(TMR_MAX + 1);

  typedef logic [NUM_CONT-1:0][KEY_BITS-1:0] key_arr_t;

  key_arr_t                       prev, pend_press, pend_rel, pend_rep;
  key_arr_t                       rise, fall, clr_press, clr_rel, clr_rep, rep_set, rep_kill;
  logic [1:0]                     scan;
  logic [NUM_CONT-1:0]            armed, arm_vld, rel_hit, held, expire;
  logic [NUM_CONT-1:0][3:0]       rep_key, arm_key;
  logic [NUM_CONT-1:0][CNT_W-1:0] rep_cnt;
  logic [KEY_BITS-1:0]            s_press, s_rel, s_rep, s_lvl, sel_oh;
  logic                           pick_vld;
  logic [3:0]                     pick_key;
  evt_kind_e                      pick_kind;
  logic                           push, pop, fifo_full, fifo_empty, ovf_set;
  evt_t                           push_evt, head_evt;

  assign rise = key_in & ~prev;
  assign fall = ~key_in & prev;
  // An edge landing on an already-pending bit of the same kind is lost.
  assign ovf_set = |(rise & pend_press) || |(fall & pend_rel);

  // Pending state of the controller under the scanner. prev is the level that
  // matches the recorded edges, so it decides press/release order.
  always_comb begin
    s_press = '0;
    s_rel   = '0;
    s_rep   = '0;
    s_lvl   = '0;
    for (int c = 0; c < NUM_CONT; c++) begin
      if (scan == 2'(c)) begin
        s_press = pend_press[c];
        s_rel   = pend_rel[c];
        s_rep   = pend_rep[c];
        s_lvl   = prev[c];
      end
    end
  end

  // Lowest key with anything pending wins; edges beat repeats, older edge first.
  always_comb begin
    pick_vld  = 1'b0;
    pick_key  = '0;
    pick_kind = EVT_PRESS;
    sel_oh    = '0;
    for (int k = KEY_BITS-1; k >= 0; k--) begin
      if (s_press[k] || s_rel[k] || s_rep[k]) begin
        pick_vld  = 1'b1;
        pick_key  = 4'(k);
        sel_oh    = '0;
        sel_oh[k] = 1'b1;
        if (s_press[k] && s_rel[k]) pick_kind = s_lvl[k] ? EVT_RELEASE : EVT_PRESS;
        else if (s_press[k])        pick_kind = EVT_PRESS;
        else if (s_rel[k])          pick_kind = EVT_RELEASE;
        else                        pick_kind = EVT_REPEAT;
      end
    end
  end

  assign pop      = evt_valid && evt_ready;
  assign push     = pick_vld && (!fifo_full || pop);
  assign push_evt = '{cont: scan, key: pick_key, kind: pick_kind};

  // Pending bit consumed by this cycle's enqueue.
  always_comb begin
    clr_press = '0;
    clr_rel   = '0;
    clr_rep   = '0;
    for (int c = 0; c < NUM_CONT; c++) begin
      if (push && scan == 2'(c)) begin
        case (pick_kind)
          EVT_PRESS:   clr_press[c] = sel_oh;
          EVT_RELEASE: clr_rel[c]   = sel_oh;
          default:     clr_rep[c]   = sel_oh;
        endcase
      end
    end
  end

  // Repeat-timer controls: arm on the lowest newly pressed key, watch rep_key.
  always_comb begin
    arm_vld  = '0;
    arm_key  = '0;
    rel_hit  = '0;
    held     = '0;
    expire   = '0;
    rep_set  = '0;
    rep_kill = '0;
    for (int c = 0; c < NUM_CONT; c++) begin
      for (int k = KEY_BITS-1; k >= 0; k--) begin
        if (rise[c][k]) begin
          arm_vld[c] = 1'b1;
          arm_key[c] = 4'(k);
        end
        if (rep_key[c] == 4'(k)) begin
          held[c]        = key_in[c][k];
          rel_hit[c]     = fall[c][k];
          rep_kill[c][k] = fall[c][k];
        end
      end
      expire[c] = armed[c] && tick && held[c] && !arm_vld[c] && (rep_cnt[c] <= CNT_W'(1));
      for (int k = 0; k < KEY_BITS; k++)
        if (rep_key[c] == 4'(k)) rep_set[c][k] = expire[c];
    end
  end

  // Edge capture into pending masks; a dropped edge leaves its bit untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= '0;
      pend_press <= '0;
      pend_rel   <= '0;
      pend_rep   <= '0;
    end else begin
      prev       <= key_in;
      pend_press <= (pend_press & ~clr_press) | (rise & ~pend_press);
      pend_rel   <= (pend_rel & ~clr_rel) | (fall & ~pend_rel);
      pend_rep   <= ((pend_rep & ~clr_rep) | rep_set) & ~rep_kill;
    end
  end

  // Per-controller repeat counters; a new press always re-arms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed   <= '0;
      rep_key <= '0;
      rep_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CONT; c++) begin
        if (arm_vld[c]) begin
          armed[c]   <= 1'b1;
          rep_key[c] <= arm_key[c];
          rep_cnt[c] <= CNT_W'(REPEAT_DELAY);
        end else if (rel_hit[c]) begin
          armed[c] <= 1'b0;
        end else if (armed[c] && tick && held[c]) begin
          rep_cnt[c] <= expire[c] ? CNT_W'(REPEAT_RATE) : rep_cnt[c] - 1'b1;
        end
      end
    end
  end

  // Round-robin scanner, one controller per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) scan <= '0;
    else          scan <= (scan == 2'(NUM_CONT-1)) ? 2'd0 : scan + 2'd1;
  end

  // Sticky overflow; a new loss in the clearing cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            overflow <= 1'b0;
    else if (ovf_set)        overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  sync_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_evt),
    .pop     (pop),
    .dout    (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_cont  = head_evt.cont;
  assign evt_key   = head_evt.key;
  assign evt_kind  = head_evt.kind;

endmodule
